// File: rtl/gpio_debounce.sv
// Per-channel 2-flop synchroniser plus stability counter for raw board inputs.
// Optional rise/fall strobes are built when GPIO_DEBOUNCE_EDGE_EN is defined.
module gpio_debounce #(
  parameter int unsigned           Width        = 3,
  parameter int unsigned           StableCycles = 60000,
  parameter logic [Width-1:0]      ResetVal     = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] gpio_i,
  output logic [Width-1:0] gpio_o
`ifdef GPIO_DEBOUNCE_EDGE_EN
  ,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
`endif
);

  localparam int unsigned CntW = (StableCycles > 1) ? $clog2(StableCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(StableCycles - 1);

  logic [Width-1:0] s1;
  logic [Width-1:0] s2;
  logic [CntW-1:0]  cnt [Width];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1 <= ResetVal;
      s2 <= ResetVal;
    end else begin
      s1 <= gpio_i;
      s2 <= s1;
    end
  end

  // Terminal compare comes before the increment, so the counter never wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gpio_o <= ResetVal;
      for (int unsigned i = 0; i < Width; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < Width; i++) begin
        if (s2[i] == gpio_o[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CntMax) begin
          gpio_o[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CntW'(1);
        end
      end
    end
  end

`ifdef GPIO_DEBOUNCE_EDGE_EN
  // gpio_prev resets to ResetVal so the reset-time force of gpio_o never strobes.
  logic [Width-1:0] gpio_prev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gpio_prev <= ResetVal;
      rise_o    <= '0;
      fall_o    <= '0;
    end else begin
      gpio_prev <= gpio_o;
      rise_o    <= gpio_o & ~gpio_prev;
      fall_o    <= ~gpio_o & gpio_prev;
    end
  end
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: expected per-cycle outputs are queued as
// stimulus is applied and compared after each clock edge.
module tb_gpio_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rst_b_n;
  logic [2:0] pins_a;
  logic [2:0] pins_b;
  logic [2:0] out_a;
  logic [2:0] out_b;
`ifdef GPIO_DEBOUNCE_EDGE_EN
  logic [2:0] rise_a, fall_a, rise_b, fall_b;
`endif

  gpio_debounce #(.Width(3), .StableCycles(4), .ResetVal(3'b000)) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .gpio_i (pins_a),
    .gpio_o (out_a)
`ifdef GPIO_DEBOUNCE_EDGE_EN
    ,
    .rise_o (rise_a),
    .fall_o (fall_a)
`endif
  );

  gpio_debounce #(.Width(3), .StableCycles(1), .ResetVal(3'b111)) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_b_n),
    .gpio_i (pins_b),
    .gpio_o (out_b)
`ifdef GPIO_DEBOUNCE_EDGE_EN
    ,
    .rise_o (rise_b),
    .fall_o (fall_b)
`endif
  );

  typedef struct {
    int         cyc;
    bit         dut;
    logic [2:0] g;
    logic [2:0] r;
    logic [2:0] f;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   plan_cyc = 0;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic plan(input bit dut, input logic [2:0] g, input logic [2:0] r,
                      input logic [2:0] f, input string tag);
    exp_t e;
    plan_cyc++;
    e.cyc = plan_cyc;
    e.dut = dut;
    e.g   = g;
    e.r   = r;
    e.f   = f;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic plan_n(input int n, input bit dut, input logic [2:0] g,
                        input logic [2:0] r, input logic [2:0] f, input string tag);
    for (int i = 0; i < n; i++) plan(dut, g, r, f, tag);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.dut == 1'b0) begin
        check({e.tag, "_gpio"}, out_a, e.g);
`ifdef GPIO_DEBOUNCE_EDGE_EN
        check({e.tag, "_rise"}, rise_a, e.r);
        check({e.tag, "_fall"}, fall_a, e.f);
`endif
      end else begin
        check({e.tag, "_gpio"}, out_b, e.g);
`ifdef GPIO_DEBOUNCE_EDGE_EN
        check({e.tag, "_rise"}, rise_b, e.r);
        check({e.tag, "_fall"}, fall_b, e.f);
`endif
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rst_b_n = 1'b0;
    pins_a  = 3'b000;
    pins_b  = 3'b101;

    // reset values of both instances
    repeat (3) begin
      tick();
      check("rst_a", out_a, 3'b000);
      check("rst_b", out_b, 3'b111);
    end
    rst_n = 1'b1;

    // idle: nothing moves for 20 cycles
    plan_cyc = cyc;
    plan_n(20, 0, 3'b000, 3'b000, 3'b000, "t1_idle");
    repeat (20) tick();

    // bit0 rise: output exactly 5 edges after the sampling edge
    pins_a   = 3'b001;
    plan_cyc = cyc;
    plan_n(5, 0, 3'b000, 3'b000, 3'b000, "t2_wait");
    plan(0, 3'b001, 3'b000, 3'b000, "t2_out");
    plan(0, 3'b001, 3'b001, 3'b000, "t2_rise");
    plan_n(3, 0, 3'b001, 3'b000, 3'b000, "t2_hold");
    repeat (10) tick();

    // bit1 high for 3 samples is rejected
    pins_a   = 3'b011;
    plan_cyc = cyc;
    plan_n(10, 0, 3'b001, 3'b000, 3'b000, "t3_glitch");
    repeat (3) tick();
    pins_a = 3'b001;
    repeat (7) tick();

    // bit1 high for 4 samples is accepted, then debounced back low
    pins_a   = 3'b011;
    plan_cyc = cyc;
    plan_n(5, 0, 3'b001, 3'b000, 3'b000, "t3b_wait");
    plan(0, 3'b011, 3'b000, 3'b000, "t3b_up");
    plan(0, 3'b011, 3'b010, 3'b000, "t3b_rise");
    plan_n(2, 0, 3'b011, 3'b000, 3'b000, "t3b_hi");
    plan(0, 3'b001, 3'b000, 3'b000, "t3b_down");
    plan(0, 3'b001, 3'b000, 3'b010, "t3b_fall");
    plan_n(2, 0, 3'b001, 3'b000, 3'b000, "t3b_lo");
    repeat (4) tick();
    pins_a = 3'b001;
    repeat (9) tick();

    // bit2: 1,1,1,0 then held 1 -> count restarts after the 0
    plan_cyc = cyc;
    plan_n(9, 0, 3'b001, 3'b000, 3'b000, "t4_wait");
    plan(0, 3'b101, 3'b000, 3'b000, "t4_up");
    plan(0, 3'b101, 3'b100, 3'b000, "t4_rise");
    plan(0, 3'b101, 3'b000, 3'b000, "t4_hold");
    pins_a = 3'b101;
    repeat (3) tick();
    pins_a = 3'b001;
    tick();
    pins_a = 3'b101;
    repeat (8) tick();

    // all high, then asynchronous reset mid-cycle and re-debounce after release
    pins_a   = 3'b111;
    plan_cyc = cyc;
    plan_n(5, 0, 3'b101, 3'b000, 3'b000, "t5_wait");
    plan(0, 3'b111, 3'b000, 3'b000, "t5_up");
    plan(0, 3'b111, 3'b010, 3'b000, "t5_rise");
    plan(0, 3'b111, 3'b000, 3'b000, "t5_hold");
    repeat (8) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_gpio", out_a, 3'b000);
`ifdef GPIO_DEBOUNCE_EDGE_EN
    check("t5_async_rise", rise_a, 3'b000);
    check("t5_async_fall", fall_a, 3'b000);
`endif
    plan_cyc = cyc;
    plan_n(2, 0, 3'b000, 3'b000, 3'b000, "t5_inrst");
    repeat (2) tick();
    rst_n    = 1'b1;
    plan_cyc = cyc;
    plan_n(5, 0, 3'b000, 3'b000, 3'b000, "t5_relwait");
    plan(0, 3'b111, 3'b000, 3'b000, "t5_rel_up");
    plan(0, 3'b111, 3'b111, 3'b000, "t5_rel_rise");
    plan(0, 3'b111, 3'b000, 3'b000, "t5_rel_hold");
    repeat (8) tick();

    // StableCycles=1, ResetVal=111, pins 101
    rst_b_n  = 1'b1;
    plan_cyc = cyc;
    plan(1, 3'b111, 3'b000, 3'b000, "t6_k");
    plan(1, 3'b111, 3'b000, 3'b000, "t6_k1");
    plan(1, 3'b101, 3'b000, 3'b000, "t6_out");
    plan(1, 3'b101, 3'b000, 3'b010, "t6_fall");
    plan(1, 3'b101, 3'b000, 3'b000, "t6_hold");
    repeat (5) tick();

    n_checks++;
    assert (q.size() == 0) else begin
      n_err++;
      $error("FAIL leftover: observed=%0d expected=0 queued entries", q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
